vlg_dist_cal: RTL and testbench

VLG_DIST_CAL -- requirements
Module: vlg_dist_cal

---
 rtl/vlg_dist_cal.sv | 118 +++++++++++
 tb/tb_vlg_dist_cal.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vlg_dist_cal.sv
// rtl/vlg_dist_cal.sv - echo time to distance converter, iterative shift-add multiply
// One sample in flight: IDLE accepts, MULT walks the coefficient bits, OUT holds the result.
module vlg_dist_cal #(
    parameter int T_W    = 16,
    parameter int COEF   = 709,
    parameter int COEF_W = 10,
    parameter int SHIFT  = 12,
    parameter int S_W    = 14
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_t_valid,
    output logic           o_t_ready,
    input  logic [T_W-1:0] i_t_us,
    output logic           o_s_valid,
    input  logic           i_s_ready,
    output logic [S_W-1:0] o_s_mm,
    output logic           o_sat,
    output logic           o_busy
);

    localparam int ACC_W = T_W + COEF_W;
    localparam int CNT_W = $clog2(COEF_W + 1);
    localparam logic [COEF_W-1:0] C_COEF = COEF_W'(COEF);
    localparam logic [ACC_W-1:0]  S_MAX  = {{(ACC_W-S_W){1'b0}}, {S_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_OUT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [T_W-1:0]     r_t;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [S_W-1:0]     r_s_mm;
    logic               r_sat;

    logic               w_accept;
    logic               w_last;
    logic [ACC_W-1:0]   w_addend;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W-1:0]   w_shifted;
    logic               w_over;

    assign w_accept   = i_t_valid && (r_state == ST_IDLE);
    assign w_last     = (r_cnt == CNT_W'(COEF_W - 1));
    assign w_addend   = C_COEF[r_cnt] ? ({{COEF_W{1'b0}}, r_t} << r_cnt) : '0;
    // The final partial product is folded in combinationally so the result lands on the last MULT edge.
    assign w_acc_next = r_acc + w_addend;
    assign w_shifted  = w_acc_next >> SHIFT;
    assign w_over     = (w_shifted > S_MAX);

    assign o_s_mm = r_s_mm;
    assign o_sat  = r_sat;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_t_ready    = 1'b0;
        o_s_valid    = 1'b0;
        o_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_t_ready = 1'b1;
                o_busy    = 1'b0;
                if (i_t_valid) begin
                    w_state_next = ST_MULT;
                end
            end
            ST_MULT: begin
                if (w_last) begin
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                o_s_valid = 1'b1;
                if (i_s_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_t    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_s_mm <= '0;
            r_sat  <= 1'b0;
        end else if (w_accept) begin
            r_t   <= i_t_us;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == ST_MULT) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_s_mm <= w_over ? {S_W{1'b1}} : w_shifted[S_W-1:0];
                r_sat  <= w_over;
            end
        end
    end

endmodule

// File: tb/tb_vlg_dist_cal.sv
// tb/tb_vlg_dist_cal.sv - scoreboard bench for vlg_dist_cal
module tb_vlg_dist_cal;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        t_valid, t_ready, s_valid, s_ready, sat, busy;
    logic [15:0] t_us;
    logic [13:0] s_mm;

    logic        t2_valid, t2_ready, s2_valid, s2_ready, sat2, busy2;
    logic [15:0] t2_us;
    logic [11:0] s2_mm;

    typedef struct {
        int unsigned mm;
        bit          sat;
    } exp_t;

    exp_t q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_pushed  = 0;
    int   n_popped  = 0;
    bit   rand_mode = 0;

    always #5 clk = ~clk;

    vlg_dist_cal dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_t_valid(t_valid), .o_t_ready(t_ready),
        .i_t_us(t_us), .o_s_valid(s_valid), .i_s_ready(s_ready), .o_s_mm(s_mm),
        .o_sat(sat), .o_busy(busy)
    );

    vlg_dist_cal #(.COEF(1023), .S_W(12)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_t_valid(t2_valid), .o_t_ready(t2_ready),
        .i_t_us(t2_us), .o_s_valid(s2_valid), .i_s_ready(s2_ready), .o_s_mm(s2_mm),
        .o_sat(sat2), .o_busy(busy2)
    );

    function automatic exp_t model(input longint unsigned t, input longint unsigned coef,
                                   input int shift, input int sw);
        exp_t            r;
        longint unsigned p, mx;
        p  = (t * coef) >> shift;
        mx = (64'd1 << sw) - 64'd1;
        if (p > mx) begin
            r.mm  = 32'(mx);
            r.sat = 1'b1;
        end else begin
            r.mm  = 32'(p);
            r.sat = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic accept(input logic [15:0] t, input bit push);
        int w;
        w = 0;
        @(posedge clk); #1;
        t_valid = 1'b1;
        t_us    = t;
        @(negedge clk);
        while (!t_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", t_ready, 1);
        if (push) begin
            q.push_back(model(t, 709, 12, 14));
            n_pushed++;
        end
        @(posedge clk); #1;
        t_valid = 1'b0;
        t_us    = 16'($urandom);
    endtask

    task automatic wait_result(input int exp_lat, input bit chk_ready);
        int lat;
        lat = 0;
        @(negedge clk);
        while (!s_valid && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, exp_lat);
        if (chk_ready) begin
            @(negedge clk);
            chk("ready_after_hs", t_ready, 1);
            chk("valid_after_hs", s_valid, 0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (s_valid && s_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got mm %0d expected none at %0t", s_mm, $time);
                end else begin
                    e = q.pop_front();
                    chk("result_mm", s_mm, e.mm);
                    chk("result_sat", sat, e.sat);
                    n_popped++;
                end
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk); #1;
            if (rand_mode) s_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        exp_t e2;
        int   lat, accepted, cyc;
        bit   stray;
        rst_n = 1'b0; t_valid = 1'b0; t_us = '0; s_ready = 1'b1;
        t2_valid = 1'b0; t2_us = '0; s2_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", s_valid, 0);
        chk("rst_mm", s_mm, 0);
        chk("rst_sat", sat, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", t_ready, 1);

        accept(16'd1000, 1);  wait_result(10, 1);
        accept(16'd65535, 1); wait_result(10, 1);
        accept(16'd0, 1);     wait_result(10, 1);

        s_ready = 1'b0;
        accept(16'd5800, 1);
        wait_result(10, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            t_valid = 1'b1;
            t_us    = 16'($urandom);
            @(negedge clk);
            chk("bp_valid", s_valid, 1);
            chk("bp_mm", s_mm, 1003);
            chk("bp_ready", t_ready, 0);
        end
        @(posedge clk); #1;
        t_valid = 1'b0;
        s_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_mm", s_mm, 1003);
        chk("hold_valid", s_valid, 0);
        chk("hold_ready", t_ready, 1);

        accept(16'd3000, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_mm", s_mm, 0);
        chk("abort_sat", sat, 0);
        stray = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (s_valid) stray = 1'b1;
        end
        chk("abort_no_valid", stray, 0);
        accept(16'd2000, 1);
        wait_result(10, 1);

        @(posedge clk); #1;
        t2_valid = 1'b1;
        t2_us    = 16'd65535;
        @(negedge clk);
        chk("sat_accept_ready", t2_ready, 1);
        @(posedge clk); #1;
        t2_valid = 1'b0;
        t2_us    = 16'd0;
        lat = 0;
        @(negedge clk);
        while (!s2_valid && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        e2 = model(65535, 1023, 12, 12);
        chk("sat_latency", lat, 10);
        chk("sat_mm", s2_mm, e2.mm);
        chk("sat_flag", sat2, e2.sat);

        rand_mode = 1;
        accepted  = 0;
        cyc       = 0;
        while (accepted < 1000 && cyc < 40000) begin
            @(posedge clk); #1;
            t_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       t_us = 16'd0;
                1:       t_us = 16'hFFFF;
                default: t_us = 16'($urandom);
            endcase
            @(negedge clk);
            if (t_valid && t_ready) begin
                q.push_back(model(t_us, 709, 12, 14));
                n_pushed++;
                accepted++;
            end
            cyc++;
        end
        chk("rand_accepted", accepted, 1000);
        @(posedge clk); #1;
        t_valid = 1'b0;
        cyc = 0;
        while (q.size() != 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_queue_empty", q.size(), 0);
        chk("popped_eq_pushed", n_popped, n_pushed);
        rand_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
